// File: rtl/counter_multispeed_if.sv
// Control and status bundle for counter_multispeed: start/stop, speed, direction,
// clear/load in; count value and strobes out.
`timescale 1ns/1ps
interface counter_multispeed_if #(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 2
);
  logic              SS;
  logic [MODE_W-1:0] MODE;
  logic              dir;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  out;
  logic              running;
  logic              tick;
  logic              carry;

  modport master (
    output SS, MODE, dir, clr, load, load_val,
    input  out, running, tick, carry
  );

  modport slave (
    input  SS, MODE, dir, clr, load, load_val,
    output out, running, tick, carry
  );
endinterface

// File: rtl/counter_multispeed.sv
// Start/stop up/down modulo counter advanced by a prescaler tick whose period
// is DIV_BASE << (SPEED_SHIFT*MODE); carry pulses on every wrap for cascading.
`timescale 1ns/1ps
module counter_multispeed #(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 255,
  parameter int MODE_W      = 2,
  parameter int DIV_BASE    = 2,
  parameter int SPEED_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  counter_multispeed_if.slave bus
);

  localparam int PMAX  = DIV_BASE << (SPEED_SHIFT * ((1 << MODE_W) - 1));
  localparam int PRE_W = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              ss_q, ss_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              tick_q, tick_d;
  logic              carry_q, carry_d;
  logic              ss_rise;
  logic              tick_fire;

  // Terminal prescaler value for a given speed select.
  function automatic logic [PRE_W-1:0] last_pre(input logic [MODE_W-1:0] m);
    int p;
    p = DIV_BASE << (SPEED_SHIFT * int'(m));
    return PRE_W'(p - 1);
  endfunction

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      ss_q    <= 1'b1;
      mode_q  <= '0;
      pre_q   <= '0;
      out_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ss_d      = bus.SS;
    mode_d    = bus.MODE;
    pre_d     = pre_q;
    out_d     = out_q;
    tick_d    = 1'b0;
    carry_d   = 1'b0;
    tick_fire = 1'b0;
    ss_rise   = bus.SS & ~ss_q;

    if (ss_rise) begin
      state_d = (state_q == ST_STOP) ? ST_RUN : ST_STOP;
    end

    // A speed change restarts the period; STOP freezes the phase.
    if (bus.MODE != mode_q) begin
      pre_d = '0;
    end else if (state_q == ST_RUN) begin
      if (pre_q == last_pre(mode_q)) begin
        pre_d     = '0;
        tick_fire = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (tick_fire) begin
      tick_d = 1'b1;
      if (bus.dir) begin
        if (out_q >= MAX_V) begin
          out_d   = '0;
          carry_d = 1'b1;
        end else begin
          out_d = out_q + 1'b1;
        end
      end else begin
        if (out_q == '0) begin
          out_d   = MAX_V;
          carry_d = 1'b1;
        end else begin
          out_d = out_q - 1'b1;
        end
      end
    end

    // Clear beats load, and both discard any tick of this cycle.
    if (bus.clr) begin
      out_d   = '0;
      pre_d   = '0;
      state_d = ST_STOP;
      tick_d  = 1'b0;
      carry_d = 1'b0;
    end else if (bus.load) begin
      out_d   = sat_load(bus.load_val);
      pre_d   = '0;
      tick_d  = 1'b0;
      carry_d = 1'b0;
    end
  end

  assign bus.out     = out_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.tick    = tick_q;
  assign bus.carry   = carry_q;

endmodule

// File: tb/tb_counter_multispeed.sv
// Directed bench for counter_multispeed at WIDTH=4, MAX_COUNT=9, DIV_BASE=2,
// SPEED_SHIFT=1, MODE_W=2.
`timescale 1ns/1ps
module tb_counter_multispeed;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  counter_multispeed_if #(.WIDTH(4), .MODE_W(2)) bus ();

  counter_multispeed #(
    .WIDTH(4), .MAX_COUNT(9), .MODE_W(2), .DIV_BASE(2), .SPEED_SHIFT(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.SS = 1'b1; bus.MODE = 2'd0; bus.dir = 1'b1;
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 4'd0;
    cyc(2);
    n_cmp++; if (bus.out !== 4'd0) begin n_err++; $display("FAIL rst_out: got %0d want 0", bus.out); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL rst_running: got %0b want 0", bus.running); end
    n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %0b want 0", bus.tick); end
    n_cmp++; if (bus.carry !== 1'b0) begin n_err++; $display("FAIL rst_carry: got %0b want 0", bus.carry); end
    reset = 1'b0;
    cyc(3);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL ss_through_reset: running got %0b want 0", bus.running); end
    bus.SS = 1'b0;
    cyc(1);
  endtask

  task automatic test_count_up;
    bus.SS = 1'b1;
    cyc(1);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL start_running: got %0b want 1", bus.running); end
    bus.SS = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      cyc(1);
      n_cmp++; if (bus.out !== 4'((i / 2) % 10)) begin n_err++; $display("FAIL up_out[%0d]: got %0d want %0d", i, bus.out, (i / 2) % 10); end
      n_cmp++; if (bus.tick !== ((i % 2) == 0)) begin n_err++; $display("FAIL up_tick[%0d]: got %0b want %0b", i, bus.tick, (i % 2) == 0); end
      n_cmp++; if (bus.carry !== (i == 20)) begin n_err++; $display("FAIL up_carry[%0d]: got %0b want %0b", i, bus.carry, i == 20); end
    end
  endtask

  task automatic test_speed;
    int exp_out;
    bus.MODE = 2'd1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      exp_out = (i < 5) ? 1 : (i < 9) ? 2 : 3;
      n_cmp++; if (bus.tick !== (i == 5 || i == 9)) begin n_err++; $display("FAIL m1_tick[%0d]: got %0b want %0b", i, bus.tick, i == 5 || i == 9); end
      n_cmp++; if (bus.out !== 4'(exp_out)) begin n_err++; $display("FAIL m1_out[%0d]: got %0d want %0d", i, bus.out, exp_out); end
    end
    // Prescaler is at its last count: the change edge would otherwise tick.
    bus.MODE = 2'd3;
    for (int i = 1; i <= 17; i++) begin
      cyc(1);
      exp_out = (i < 17) ? 3 : 4;
      n_cmp++; if (bus.tick !== (i == 17)) begin n_err++; $display("FAIL m3_tick[%0d]: got %0b want %0b", i, bus.tick, i == 17); end
      n_cmp++; if (bus.out !== 4'(exp_out)) begin n_err++; $display("FAIL m3_out[%0d]: got %0d want %0d", i, bus.out, exp_out); end
    end
  endtask

  task automatic test_down;
    int exp_out;
    bus.MODE = 2'd0; bus.dir = 1'b0;
    bus.load = 1'b1; bus.load_val = 4'd0;
    cyc(1);
    bus.load = 1'b0;
    n_cmp++; if (bus.out !== 4'd0) begin n_err++; $display("FAIL dn_load0: got %0d want 0", bus.out); end
    for (int i = 2; i <= 9; i++) begin
      cyc(1);
      exp_out = (i < 3) ? 0 : 10 - (i - 1) / 2;
      n_cmp++; if (bus.out !== 4'(exp_out)) begin n_err++; $display("FAIL dn_out[%0d]: got %0d want %0d", i, bus.out, exp_out); end
      n_cmp++; if (bus.carry !== (i == 3)) begin n_err++; $display("FAIL dn_carry[%0d]: got %0b want %0b", i, bus.carry, i == 3); end
    end
  endtask

  task automatic test_load;
    bus.load = 1'b1; bus.load_val = 4'd12;
    cyc(1);
    bus.load = 1'b0;
    n_cmp++; if (bus.out !== 4'd9) begin n_err++; $display("FAIL ld_sat: got %0d want 9", bus.out); end
    cyc(1);
    n_cmp++; if (bus.out !== 4'd9) begin n_err++; $display("FAIL ld_hold: got %0d want 9", bus.out); end
    // Next edge is a tick that would wrap 9->0 with carry.
    bus.dir = 1'b1; bus.load = 1'b1; bus.load_val = 4'd3;
    cyc(1);
    bus.load = 1'b0;
    n_cmp++; if (bus.out !== 4'd3) begin n_err++; $display("FAIL ld_tick_out: got %0d want 3", bus.out); end
    n_cmp++; if (bus.carry !== 1'b0) begin n_err++; $display("FAIL ld_tick_carry: got %0b want 0", bus.carry); end
    n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL ld_tick_tick: got %0b want 0", bus.tick); end
    cyc(2);
    n_cmp++; if (bus.out !== 4'd4) begin n_err++; $display("FAIL ld_resume: got %0d want 4", bus.out); end
    bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 4'd5;
    cyc(1);
    bus.clr = 1'b0; bus.load = 1'b0;
    n_cmp++; if (bus.out !== 4'd0) begin n_err++; $display("FAIL clr_ld_out: got %0d want 0", bus.out); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL clr_ld_running: got %0b want 0", bus.running); end
    cyc(3);
    n_cmp++; if (bus.out !== 4'd0) begin n_err++; $display("FAIL clr_hold: got %0d want 0", bus.out); end
  endtask

  task automatic test_start_stop;
    bus.SS = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL ss_held[%0d]: got %0b want 1", i, bus.running); end
    end
    n_cmp++; if (bus.out !== 4'd4) begin n_err++; $display("FAIL ss_held_out: got %0d want 4", bus.out); end
    bus.SS = 1'b0;
    cyc(1);
    n_cmp++; if (bus.out !== 4'd5) begin n_err++; $display("FAIL pre_stop_out: got %0d want 5", bus.out); end
    bus.SS = 1'b1;
    cyc(1);
    bus.SS = 1'b0;
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL stop_running: got %0b want 0", bus.running); end
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      n_cmp++; if (bus.out !== 4'd5) begin n_err++; $display("FAIL stop_hold[%0d]: got %0d want 5", i, bus.out); end
      n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL stop_tick[%0d]: got %0b want 0", i, bus.tick); end
    end
    bus.SS = 1'b1;
    cyc(1);
    bus.SS = 1'b0;
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL resume_running: got %0b want 1", bus.running); end
    n_cmp++; if (bus.out !== 4'd5) begin n_err++; $display("FAIL resume_out0: got %0d want 5", bus.out); end
    cyc(1);
    n_cmp++; if (bus.tick !== 1'b1) begin n_err++; $display("FAIL resume_phase_tick: got %0b want 1", bus.tick); end
    n_cmp++; if (bus.out !== 4'd6) begin n_err++; $display("FAIL resume_phase_out: got %0d want 6", bus.out); end
  endtask

  task automatic test_reset_mid;
    bus.load = 1'b1; bus.load_val = 4'd5;
    cyc(1);
    bus.load = 1'b0;
    n_cmp++; if (bus.out !== 4'd5) begin n_err++; $display("FAIL mid_pre_out: got %0d want 5", bus.out); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.out !== 4'd0) begin n_err++; $display("FAIL mid_rst_out: got %0d want 0", bus.out); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL mid_rst_running: got %0b want 0", bus.running); end
    n_cmp++; if (bus.carry !== 1'b0) begin n_err++; $display("FAIL mid_rst_carry: got %0b want 0", bus.carry); end
    cyc(1);
    reset = 1'b0;
    cyc(4);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL post_rst_running: got %0b want 0", bus.running); end
    n_cmp++; if (bus.out !== 4'd0) begin n_err++; $display("FAIL post_rst_out: got %0d want 0", bus.out); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_speed();
    test_down();
    test_load();
    test_start_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
